// File: rtl/schmidl_cox_preamble_inserter.sv
// Schmidl-Cox TX framer: two identical preamble halves from a small RAM, then frame_len payload samples, tlast per burst.
// Define SCHMIDL_COX_TX_GUARD_EN to append GUARD_LEN zero samples after the payload.
module schmidl_cox_preamble_inserter #(
  parameter int ITEM_W      = 32,
  parameter int HALF_LEN    = 64,
  parameter int FRAME_LEN_W = 16,
  parameter int GUARD_LEN   = 16
) (
  input  logic                        ce_clk,
  input  logic                        ce_rst,
  input  logic                        enable,
  input  logic [FRAME_LEN_W-1:0]      frame_len,
  input  logic                        pre_wr_en,
  input  logic [$clog2(HALF_LEN)-1:0] pre_wr_addr,
  input  logic [ITEM_W-1:0]           pre_wr_data,
  input  logic [ITEM_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [ITEM_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic [31:0]                 frame_count,
  output logic                        err_tlast,
  input  logic                        clear_err
);

  localparam int ADDR_W = $clog2(HALF_LEN);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PRE_A   = 3'd1;
  localparam logic [2:0] PRE_B   = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
`ifdef SCHMIDL_COX_TX_GUARD_EN
  localparam logic [2:0] GUARD   = 3'd4;
  localparam logic       GUARD_ON = 1'b1;
`else
  localparam logic       GUARD_ON = 1'b0;
`endif

  if (HALF_LEN < 2 || (HALF_LEN & (HALF_LEN - 1)) != 0 || GUARD_LEN < 1) begin : g_param_check
    $error("schmidl_cox_preamble_inserter: HALF_LEN must be a power of two >= 2 and GUARD_LEN >= 1");
  end

  logic [2:0]             state;
  logic [ITEM_W-1:0]      pre_ram [HALF_LEN];
  logic [ADDR_W-1:0]      rd_addr;
  logic [FRAME_LEN_W-1:0] len_q;
  logic [FRAME_LEN_W-1:0] pay_cnt;
  logic [ITEM_W-1:0]      data_p0;
  logic                   vld_p0;
  logic                   last_p0;

  logic adv;
  logic start;
  logic issue;
  logic rd_wrap;
  logic pay_last;
  logic s_fire;
  logic burst_done;

  // The whole pipeline stalls only when the output register is full and not taken.
  assign adv        = !m_axis_tvalid || m_axis_tready;
  assign start      = (state == IDLE) && enable && s_axis_tvalid;
  assign issue      = (state == PRE_A) || (state == PRE_B);
  assign rd_wrap    = (rd_addr == ADDR_W'(HALF_LEN - 1));
  assign pay_last   = (pay_cnt == len_q - FRAME_LEN_W'(1));
  assign busy       = (state != IDLE);
  // Payload waits for the last preamble sample to leave the RAM stage so order is kept.
  assign s_axis_tready = (state == PAYLOAD) && !vld_p0 && adv && (pay_cnt != len_q);
  assign s_fire     = s_axis_tready && s_axis_tvalid;
  assign burst_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

`ifdef SCHMIDL_COX_TX_GUARD_EN
  localparam int GUARD_CW = $clog2(GUARD_LEN + 1);
  logic [GUARD_CW-1:0] guard_cnt;
  logic                guard_fire;
  logic                guard_last;

  assign guard_fire = (state == GUARD) && adv && !vld_p0 && (guard_cnt != GUARD_CW'(GUARD_LEN));
  assign guard_last = (guard_cnt == GUARD_CW'(GUARD_LEN - 1));

  always_ff @(posedge ce_clk) begin
    if (ce_rst || state == IDLE) begin
      guard_cnt <= '0;
    end else if (guard_fire) begin
      guard_cnt <= guard_cnt + GUARD_CW'(1);
    end
  end
`endif

  // Preamble RAM is only writable while idle and not starting, so a burst never sees a torn half.
  always_ff @(posedge ce_clk) begin
    if (pre_wr_en && state == IDLE && !start) begin
      pre_ram[pre_wr_addr] <= pre_wr_data;
    end
  end

  // Stage p0: synchronous RAM read
  always_ff @(posedge ce_clk) begin
    if (adv && issue) begin
      data_p0 <= pre_ram[rd_addr];
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      len_q         <= '0;
      pay_cnt       <= '0;
      vld_p0        <= 1'b0;
      last_p0       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      frame_count   <= '0;
      err_tlast     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRE_A;
            len_q   <= frame_len;
            rd_addr <= '0;
            pay_cnt <= '0;
          end
        end
        PRE_A: begin
          if (adv) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (rd_wrap) state <= PRE_B;
          end
        end
        PRE_B: begin
          if (adv) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (rd_wrap) begin
`ifdef SCHMIDL_COX_TX_GUARD_EN
              state <= (len_q == '0) ? GUARD : PAYLOAD;
`else
              state <= PAYLOAD;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (s_fire) begin
            pay_cnt <= pay_cnt + FRAME_LEN_W'(1);
`ifdef SCHMIDL_COX_TX_GUARD_EN
            if (pay_last) state <= GUARD;
`endif
          end
        end
`ifdef SCHMIDL_COX_TX_GUARD_EN
        GUARD: ;
`endif
        default: state <= IDLE;
      endcase

      // The final sample of a burst is the only one carrying tlast.
      if (burst_done) begin
        state       <= IDLE;
        frame_count <= frame_count + 32'd1;
      end

      if (s_fire && (s_axis_tlast != pay_last)) begin
        err_tlast <= 1'b1;
      end else if (clear_err) begin
        err_tlast <= 1'b0;
      end

      // Output register stage
      if (adv) begin
        vld_p0  <= issue;
        last_p0 <= (state == PRE_B) && rd_wrap && (len_q == '0) && !GUARD_ON;
        if (vld_p0) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= data_p0;
          m_axis_tlast  <= last_p0;
        end else if (s_fire) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= s_axis_tdata;
          m_axis_tlast  <= pay_last && !GUARD_ON;
`ifdef SCHMIDL_COX_TX_GUARD_EN
        end else if (guard_fire) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= '0;
          m_axis_tlast  <= guard_last;
`endif
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end

endmodule
